// File: rtl/dlx_fetch_pkg.sv
// Shared types and constants for the DLX instruction fetch stage.
package dlx_fetch_pkg;

  // DLX NOP (opcode 0x15), presented to decode while the queue is empty.
  localparam logic [31:0] DLX_NOP_INSTR = 32'h5400_0000;
  localparam logic [31:0] DLX_RESET_PC  = 32'h0000_0000;
  localparam int unsigned QUEUE_DEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // One prefetched instruction and the address following it.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_queue.sv
// Two-entry prefetch FIFO: push, pop, synchronous flush, occupancy and head read.
// Flush wins over push and pop; pop from an empty queue does nothing.
module dlx_fetch_queue
  import dlx_fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign count_o = count_q;
  assign head_o  = e0_q;

  // Next-state of the two slots; e0 is always the head.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_i && pop_ok) begin
      if (count_q == 2'd1) begin
        e0_d = wdata_i;
      end else begin
        e0_d = e1_q;
        e1_d = wdata_i;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        e0_d    = wdata_i;
        count_d = 2'd1;
      end else if (count_q == 2'd1) begin
        e1_d    = wdata_i;
        count_d = 2'd2;
      end
    end else if (pop_ok) begin
      e0_d    = e1_q;
      count_d = count_q - 2'd1;
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction fetch stage: PC, single-outstanding IMEM requests, 2-entry
// prefetch queue and valid/ready handoff of IR + NPC to decode.
// Optional macro DLX_FETCH_PERF_EN adds a saturating FETCH_COUNT transfer counter.
module dlx_fetch_unit
  import dlx_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DLX_RESET_PC),
  parameter logic [31:0]           NOP_INSTR  = DLX_NOP_INSTR
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic                  IMEM_REQ,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic                  IMEM_ACK,
  input  logic [31:0]           IMEM_RDATA,
  output logic [31:0]           IR_OUT,
  output logic                  IR_VALID,
  input  logic                  IR_READY,
  output logic [ADDR_WIDTH-1:0] NPC_OUT,
  input  logic                  REDIRECT_EN,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_PC
`ifdef DLX_FETCH_PERF_EN
  ,
  output logic [31:0]           FETCH_COUNT
`endif
);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] pc_plus4, redirect_pc;
  logic                  q_push, q_flush, transfer;
  logic [1:0]            q_count;
  fetch_entry_t          q_wdata, q_head;

  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign redirect_pc = {REDIRECT_PC[ADDR_WIDTH-1:2], 2'b00};
  assign transfer    = IR_VALID && IR_READY;
  assign q_flush     = REDIRECT_EN;
  assign q_wdata     = '{ir: IMEM_RDATA, npc: 32'(pc_plus4)};

  dlx_fetch_queue u_queue (
    .clk_i   (Clk),
    .rst_i   (Rst),
    .push_i  (q_push),
    .pop_i   (transfer),
    .flush_i (q_flush),
    .wdata_i (q_wdata),
    .count_o (q_count),
    .head_o  (q_head)
  );

  // Fetch FSM: issue only when a slot is guaranteed free, drain a stale ack after redirect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    q_push  = 1'b0;
    if (REDIRECT_EN) begin
      pc_d = redirect_pc;
    end
    unique case (state_q)
      IDLE: begin
        if (!REDIRECT_EN && (q_count < 2'd2)) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (IMEM_ACK) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!REDIRECT_EN) begin
            q_push = 1'b1;
            pc_d   = pc_plus4;
          end
        end else if (REDIRECT_EN) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (IMEM_ACK) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM, PC and request registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  assign IMEM_REQ  = req_q;
  assign IMEM_ADDR = addr_q;
  assign IR_VALID  = (q_count != 2'd0);
  assign IR_OUT    = IR_VALID ? q_head.ir : NOP_INSTR;
  assign NPC_OUT   = IR_VALID ? ADDR_WIDTH'(q_head.npc) : '0;

`ifdef DLX_FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  // Saturating count of completed decode transfers, redirect-coincident ones included.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (transfer && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetch_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign FETCH_COUNT = fetch_count_q;
`endif

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Directed self-checking bench for dlx_fetch_unit.
module tb_dlx_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] IR_OUT;
  logic        IR_VALID;
  logic        IR_READY;
  logic [31:0] NPC_OUT;
  logic        REDIRECT_EN;
  logic [31:0] REDIRECT_PC;
`ifdef DLX_FETCH_PERF_EN
  logic [31:0] FETCH_COUNT;
`endif

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] NOP = 32'h5400_0000;

  dlx_fetch_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_ACK    (IMEM_ACK),
    .IMEM_RDATA  (IMEM_RDATA),
    .IR_OUT      (IR_OUT),
    .IR_VALID    (IR_VALID),
    .IR_READY    (IR_READY),
    .NPC_OUT     (NPC_OUT),
    .REDIRECT_EN (REDIRECT_EN),
    .REDIRECT_PC (REDIRECT_PC)
`ifdef DLX_FETCH_PERF_EN
    ,
    .FETCH_COUNT (FETCH_COUNT)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    IMEM_ACK = 1'b0;
    IR_READY = 1'b0;
    REDIRECT_EN = 1'b0;
    step();
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; IMEM_ACK = 1'b0; IMEM_RDATA = '0; IR_READY = 1'b0;
    REDIRECT_EN = 1'b0; REDIRECT_PC = '0;

    // Reset state
    step();
    chk("rst_req", IMEM_REQ, 1'b0);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_valid", IR_VALID, 1'b0);
    chk("rst_ir", IR_OUT, NOP);
    chk("rst_npc", NPC_OUT, 32'h0);
`ifdef DLX_FETCH_PERF_EN
    chk("rst_cnt", FETCH_COUNT, 32'h0);
`endif
    step();
    Rst = 1'b0;

    // Streaming with IR_READY=1 and 1-cycle memory
    IR_READY = 1'b1;
    step();
    chk("t1_req0", IMEM_REQ, 1'b1);
    chk("t1_addr0", IMEM_ADDR, 32'h0);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h2001_0001; step(); IMEM_ACK = 1'b0;
    chk("t1_ir0", IR_OUT, 32'h2001_0001);
    chk("t1_npc0", NPC_OUT, 32'h4);
    chk("t1_reqlo", IMEM_REQ, 1'b0);
    step();
    chk("t1_addr1", IMEM_ADDR, 32'h4);
    chk("t1_req1", IMEM_REQ, 1'b1);
    chk("t1_popped", IR_VALID, 1'b0);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h2002_0002; step(); IMEM_ACK = 1'b0;
    chk("t1_ir1", IR_OUT, 32'h2002_0002);
    chk("t1_npc1", NPC_OUT, 32'h8);
    step();
    chk("t1_addr2", IMEM_ADDR, 32'h8);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h8C03_0003; step(); IMEM_ACK = 1'b0;
    chk("t1_ir2", IR_OUT, 32'h8C03_0003);
    chk("t1_npc2", NPC_OUT, 32'hC);

    // Backpressure: two words fill the queue, no further request
    do_reset();
    step();
    chk("t2_addr0", IMEM_ADDR, 32'h0);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hAC01_0000; step(); IMEM_ACK = 1'b0;
    step();
    chk("t2_addr1", IMEM_ADDR, 32'h4);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hAC02_0000; step(); IMEM_ACK = 1'b0;
    chk("t2_head", IR_OUT, 32'hAC01_0000);
    chk("t2_hnpc", NPC_OUT, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_noreq", IMEM_REQ, 1'b0);
    end
    IR_READY = 1'b1; step(); IR_READY = 1'b0;
    chk("t2_pop_ir", IR_OUT, 32'hAC02_0000);
    chk("t2_pop_npc", NPC_OUT, 32'h8);
    chk("t2_pop_noreq", IMEM_REQ, 1'b0);
    step();
    chk("t2_req8", IMEM_REQ, 1'b1);
    chk("t2_addr8", IMEM_ADDR, 32'h8);
    step();
    chk("t2_hold_req", IMEM_REQ, 1'b1);
    chk("t2_hold_valid", IR_VALID, 1'b1);

    // Redirect while the 0x8 request is outstanding
    REDIRECT_EN = 1'b1; REDIRECT_PC = 32'h0000_0101; step(); REDIRECT_EN = 1'b0;
    chk("t3_valid", IR_VALID, 1'b0);
    chk("t3_ir", IR_OUT, NOP);
    chk("t3_npc", NPC_OUT, 32'h0);
    chk("t3_req", IMEM_REQ, 1'b1);
    chk("t3_addr", IMEM_ADDR, 32'h8);
    step();
    chk("t3_drain_addr", IMEM_ADDR, 32'h8);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF; step(); IMEM_ACK = 1'b0;
    chk("t3_drop_valid", IR_VALID, 1'b0);
    chk("t3_drop_req", IMEM_REQ, 1'b0);
    step();
    chk("t3_new_req", IMEM_REQ, 1'b1);
    chk("t3_new_addr", IMEM_ADDR, 32'h100);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h0800_0040; step(); IMEM_ACK = 1'b0;
    chk("t3_ir_new", IR_OUT, 32'h0800_0040);
    chk("t3_npc_new", NPC_OUT, 32'h104);

    // Redirect together with ack and a decode transfer
    step();
    chk("t4_addr", IMEM_ADDR, 32'h104);
    chk("t4_valid", IR_VALID, 1'b1);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hBAD0_0BAD; IR_READY = 1'b1;
    REDIRECT_EN = 1'b1; REDIRECT_PC = 32'h200;
    step();
    IMEM_ACK = 1'b0; IR_READY = 1'b0; REDIRECT_EN = 1'b0;
    chk("t4_empty", IR_VALID, 1'b0);
    chk("t4_ir_nop", IR_OUT, NOP);
    chk("t4_reqlo", IMEM_REQ, 1'b0);
    step();
    chk("t4_req", IMEM_REQ, 1'b1);
    chk("t4_addr200", IMEM_ADDR, 32'h200);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h1000_0010; step(); IMEM_ACK = 1'b0;
    chk("t4_ir", IR_OUT, 32'h1000_0010);
    chk("t4_npc", NPC_OUT, 32'h204);

    // PC wrap from 0xFFFF_FFFC
    REDIRECT_EN = 1'b1; REDIRECT_PC = 32'hFFFF_FFFC; IR_READY = 1'b1;
    step();
    REDIRECT_EN = 1'b0; IR_READY = 1'b0;
    chk("t5_valid", IR_VALID, 1'b0);
    chk("t5_reqlo", IMEM_REQ, 1'b0);
    step();
    chk("t5_addr_top", IMEM_ADDR, 32'hFFFF_FFFC);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h2000_0004; step(); IMEM_ACK = 1'b0;
    chk("t5_ir", IR_OUT, 32'h2000_0004);
    chk("t5_npc_wrap", NPC_OUT, 32'h0);
    IR_READY = 1'b1; step(); IR_READY = 1'b0;
    chk("t5_addr_wrap", IMEM_ADDR, 32'h0);
    chk("t5_req_wrap", IMEM_REQ, 1'b1);

    // Reset pulse while WAIT, then a late ack
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h3000_0000; step(); IMEM_ACK = 1'b0;
    chk("t6_ir_q", IR_OUT, 32'h3000_0000);
    step();
    chk("t6_addr4", IMEM_ADDR, 32'h4);
    chk("t6_valid_pre", IR_VALID, 1'b1);
    #1 Rst = 1'b1;
    #1;
    chk("t6_req", IMEM_REQ, 1'b0);
    chk("t6_addr", IMEM_ADDR, 32'h0);
    chk("t6_valid", IR_VALID, 1'b0);
    chk("t6_ir", IR_OUT, NOP);
    chk("t6_npc", NPC_OUT, 32'h0);
`ifdef DLX_FETCH_PERF_EN
    chk("t6_cnt0", FETCH_COUNT, 32'h0);
`endif
    step();
    Rst = 1'b0; IMEM_ACK = 1'b1; IMEM_RDATA = 32'hEEEE_EEEE;
    step();
    IMEM_ACK = 1'b0;
    chk("t6_late_valid", IR_VALID, 1'b0);
    chk("t6_late_req", IMEM_REQ, 1'b1);
    chk("t6_late_addr", IMEM_ADDR, 32'h0);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h4000_0000; step(); IMEM_ACK = 1'b0;
    chk("t6_ir_r", IR_OUT, 32'h4000_0000);
    chk("t6_npc_r", NPC_OUT, 32'h4);
    IR_READY = 1'b1; step(); IR_READY = 1'b0;
    chk("t6_popped", IR_VALID, 1'b0);
`ifdef DLX_FETCH_PERF_EN
    chk("t6_cnt1", FETCH_COUNT, 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
